mcpu_gen: RTL

- Parametrised successor of the team's minimal 8-bit accumulator CPU: same four-instruction ISA (NOR, ADD, STA, JCC) with a generic data and address width.
- Memory ports are split (separate rdata/wdata, no tri-state) and carry a `ready` handshake, so the core can sit behind slow or shared memory with wait states.
- Adds a self-loop halt detector.
- Intended as the CPU tile driven by the project's SRAM/bus wrapper.

---
 rtl/mcpu_gen_pkg.sv | 26 ++
 rtl/mcpu_gen_alu.sv | 34 +++
 rtl/mcpu_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mcpu_gen_pkg.sv
// mcpu_gen_pkg
// Shared definitions for the mcpu_gen accumulator core:
//   - opcode encodings carried in the top two bits of every instruction word
//   - the controller state enum
//   - a helper that tells which states present a memory read
package mcpu_gen_pkg;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_NOR,
    ST_ADD,
    ST_STA,
    ST_CLRC
  } state_t;

  // FETCH reads the instruction, NOR/ADD read their operand.
  function automatic logic is_read_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_NOR) || (s == ST_ADD);
  endfunction

endpackage

// File: rtl/mcpu_gen_alu.sv
// mcpu_gen_alu
// Combinational datapath for the two arithmetic/logic instructions.
// Ports:
//   acc       in  DW  current accumulator
//   operand   in  DW  operand word read from memory
//   op        in  2   OP_ADD selects addition, anything else selects NOR
//   result    out DW  new accumulator value
//   carry_out out 1   carry out of the DW-bit addition (0 for NOR)
module mcpu_gen_alu
  import mcpu_gen_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  logic [1:0]    op,
  output logic [DW-1:0] result,
  output logic          carry_out
);

  logic [DW:0] sum;

  // The sum is formed one bit wider so the carry falls out of the top bit.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, operand};
    result    = ~(acc | operand);
    carry_out = 1'b0;
    if (op == OP_ADD) begin
      result    = sum[DW-1:0];
      carry_out = sum[DW];
    end
  end

endmodule

// File: rtl/mcpu_gen.sv
// mcpu_gen
// Parametrised accumulator CPU with a four-instruction ISA (NOR, ADD, STA,
// JCC). Instruction word = {opcode[1:0], operand address[DW-3:0]}.
// Memory interface is split read/write with a ready handshake; any state
// that presents an access waits while ready=0.
// Ports:
//   clk    in  1   clock, rising edge
//   rst    in  1   asynchronous active-low reset
//   rdata  in  DW  memory read data, used only when ready=1
//   ready  in  1   memory completes the presented access this cycle
//   addr   out AW  memory address (AW = DW-2)
//   rd_en  out 1   read presented (instruction fetch or operand read)
//   wr_en  out 1   write presented (STA)
//   wdata  out DW  accumulator, always driven
//   carry  out 1   carry flag
//   halt   out 1   sticky flag: a taken JCC jumped to its own address
module mcpu_gen
  import mcpu_gen_pkg::*;
#(
  parameter int             DW       = 8,
  parameter logic [DW-3:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rdata,
  input  logic          ready,
  output logic [DW-3:0] addr,
  output logic          rd_en,
  output logic          wr_en,
  output logic [DW-1:0] wdata,
  output logic          carry,
  output logic          halt
);

  localparam int AW = DW - 2;

  state_t        state;
  logic [DW-1:0] acc;
  logic [AW-1:0] adreg;
  logic [AW-1:0] pc;

  logic [1:0]    opcode;
  logic [AW-1:0] target;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_carry;

  assign opcode = rdata[DW-1:DW-2];
  assign target = rdata[AW-1:0];
  assign alu_op = (state == ST_ADD) ? OP_ADD : OP_NOR;

  mcpu_gen_alu #(
    .DW(DW)
  ) u_alu (
    .acc      (acc),
    .operand  (rdata),
    .op       (alu_op),
    .result   (alu_result),
    .carry_out(alu_carry)
  );

  assign addr  = adreg;
  assign wdata = acc;

  // Reset parks the FSM in FETCH, so the strobes are also gated by rst to
  // keep the bus quiet while reset is held and to drop them the instant
  // reset is asserted, even mid-access.
  assign rd_en = rst & is_read_state(state);
  assign wr_en = rst & (state == ST_STA);

  // Every access state only advances on ready=1, so rdata is never
  // sampled during a wait state. CLRC presents no access and ignores ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FETCH;
      acc   <= '0;
      carry <= 1'b0;
      adreg <= RESET_PC;
      pc    <= RESET_PC;
      halt  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (ready) begin
            pc    <= adreg + 1'b1;
            adreg <= target;
            case (opcode)
              OP_NOR:  state <= ST_NOR;
              OP_ADD:  state <= ST_ADD;
              OP_STA:  state <= ST_STA;
              default: begin
                // JCC: taken when carry is clear; the operand address
                // loaded into adreg above is already the jump target.
                if (carry) begin
                  state <= ST_CLRC;
                end else begin
                  state <= ST_FETCH;
                  if (target == adreg) begin
                    halt <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        ST_NOR: begin
          if (ready) begin
            acc   <= alu_result;
            adreg <= pc;
            state <= ST_FETCH;
          end
        end
        ST_ADD: begin
          if (ready) begin
            acc   <= alu_result;
            carry <= alu_carry;
            adreg <= pc;
            state <= ST_FETCH;
          end
        end
        ST_STA: begin
          if (ready) begin
            adreg <= pc;
            state <= ST_FETCH;
          end
        end
        ST_CLRC: begin
          carry <= 1'b0;
          adreg <= pc;
          state <= ST_FETCH;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule
